// File: rtl/ahb_mtx_dec_param.sv
// ahb_mtx_dec_param -- AHB bus-matrix input-stage decoder, one per slave interface.
//
// Decodes HADDR[31:10] against NUM_MI per-port address regions (sparse
// connectivity via PORT_EN) and drives a one-hot sel_mi. The data-phase
// response is muxed from the port that owns the data phase, or from a
// built-in default slave that answers unmapped NONSEQ/SEQ transfers with a
// two-cycle ERROR. The first failing address is captured until err_clr.
//
// Optional feature: define AHB_DEC_PROT_CHECK_EN to make ports flagged in
// PRIV_MASK reject unprivileged accesses (they then route to the default slave).
//
// Ports:
//   HCLK, HRESET        clock, synchronous active-high reset
//   HREADYS             slave-interface HREADY
//   sel_dec             HSEL
//   decode_addr_dec     HADDR[31:10]
//   trans_dec           HTRANS
//   prot_dec            HPROT[1] (privileged)
//   err_clr             clears the error capture
//   active_mi           per-port output-stage active flags
//   readyout_mi         per-port HREADYOUT
//   resp_mi             per-port HRESP (2 bits each)
//   rdata_mi/ruser_mi   per-port HRDATA/HRUSER
//   sel_mi              one-hot HSEL to the output stages
//   active_dec          active flag of the addressed port
//   HREADYOUTS/HRESPS   response to the slave interface
//   HRDATAS/HRUSERS     read data / user data to the slave interface
//   err_valid/err_addr  error capture
module ahb_mtx_dec_param #(
  parameter int unsigned          NUM_MI       = 4,
  parameter int unsigned          DATA_W       = 32,
  parameter int unsigned          RUSER_W      = 32,
  parameter logic [NUM_MI-1:0]    PORT_EN      = '1,
  parameter logic [22*NUM_MI-1:0] REGION_BASE  = '0,
  parameter logic [22*NUM_MI-1:0] REGION_LIMIT = '1,
  parameter logic [NUM_MI-1:0]    PRIV_MASK    = '0
) (
  input  logic                        HCLK,
  input  logic                        HRESET,
  input  logic                        HREADYS,
  input  logic                        sel_dec,
  input  logic [21:0]                 decode_addr_dec,
  input  logic [1:0]                  trans_dec,
  input  logic                        prot_dec,
  input  logic                        err_clr,
  input  logic [NUM_MI-1:0]           active_mi,
  input  logic [NUM_MI-1:0]           readyout_mi,
  input  logic [2*NUM_MI-1:0]         resp_mi,
  input  logic [DATA_W*NUM_MI-1:0]    rdata_mi,
  input  logic [RUSER_W*NUM_MI-1:0]   ruser_mi,
  output logic [NUM_MI-1:0]           sel_mi,
  output logic                        active_dec,
  output logic                        HREADYOUTS,
  output logic [1:0]                  HRESPS,
  output logic [DATA_W-1:0]           HRDATAS,
  output logic [RUSER_W-1:0]          HRUSERS,
  output logic                        err_valid,
  output logic [21:0]                 err_addr
);

  // Port index width covers 0..NUM_MI; index NUM_MI is the default slave.
  localparam int unsigned     PW = $clog2(NUM_MI + 1);
  localparam logic [PW-1:0]   DS = PW'(NUM_MI);

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  ds_state_e         ds_state_q;
  logic              ds_ready_q;
  logic [1:0]        ds_resp_q;

  logic [NUM_MI-1:0] hit;
  logic [PW-1:0]     hit_port;
  logic [PW-1:0]     addr_port;
  logic [PW-1:0]     data_port_q, data_port_d;
  logic              err_valid_q, err_valid_d;
  logic [21:0]       err_addr_q, err_addr_d;
  logic              ds_take;
  logic              err_set;

  // Region match per port, masked by connectivity (and privilege if enabled).
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NUM_MI; i++) begin
      hit[i] = PORT_EN[i]
             && (decode_addr_dec >= REGION_BASE[22*i +: 22])
             && (decode_addr_dec <= REGION_LIMIT[22*i +: 22]);
`ifdef AHB_DEC_PROT_CHECK_EN
      if (PRIV_MASK[i] && !prot_dec) hit[i] = 1'b0;
`endif
    end
  end

`ifndef AHB_DEC_PROT_CHECK_EN
  logic unused_prot;
  assign unused_prot = prot_dec;
`endif

  // Descending scan so the lowest-index hit is the last write and wins.
  always_comb begin
    hit_port = DS;
    for (int unsigned i = NUM_MI; i > 0; i--) begin
      if (hit[i-1]) hit_port = PW'(i - 1);
    end
  end

  // IDLE transfers stay on the current data-phase port to avoid needless
  // re-arbitration in the output stages.
  assign addr_port = (trans_dec == 2'b00 && data_port_q != DS) ? data_port_q : hit_port;

  always_comb begin
    sel_mi     = '0;
    active_dec = 1'b1;
    for (int unsigned i = 0; i < NUM_MI; i++) begin
      if (addr_port == PW'(i)) begin
        sel_mi[i]  = sel_dec;
        active_dec = active_mi[i];
      end
    end
  end

  always_comb begin
    HREADYOUTS = ds_ready_q;
    HRESPS     = ds_resp_q;
    HRDATAS    = '0;
    HRUSERS    = '0;
    for (int unsigned i = 0; i < NUM_MI; i++) begin
      if (data_port_q == PW'(i)) begin
        HREADYOUTS = readyout_mi[i];
        HRESPS     = resp_mi[2*i +: 2];
        HRDATAS    = rdata_mi[DATA_W*i +: DATA_W];
        HRUSERS    = ruser_mi[RUSER_W*i +: RUSER_W];
      end
    end
  end

  assign ds_take = sel_dec && HREADYS && trans_dec[1] && (addr_port == DS);
  assign err_set = ds_take && (ds_state_q != DS_ERR1);

  // Default slave: two-cycle ERROR, response registered with the state.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ds_state_q <= DS_IDLE;
      ds_ready_q <= 1'b1;
      ds_resp_q  <= 2'b00;
    end else begin
      case (ds_state_q)
        DS_ERR1: begin
          ds_state_q <= DS_ERR2;
          ds_ready_q <= 1'b1;
          ds_resp_q  <= 2'b01;
        end
        default: begin
          if (ds_take) begin
            ds_state_q <= DS_ERR1;
            ds_ready_q <= 1'b0;
            ds_resp_q  <= 2'b01;
          end else begin
            ds_state_q <= DS_IDLE;
            ds_ready_q <= 1'b1;
            ds_resp_q  <= 2'b00;
          end
        end
      endcase
    end
  end

  // A new error coinciding with err_clr wins over the clear.
  always_comb begin
    data_port_d = HREADYS ? addr_port : data_port_q;
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    if (err_set && (!err_valid_q || err_clr)) begin
      err_valid_d = 1'b1;
      err_addr_d  = decode_addr_dec;
    end else if (err_clr) begin
      err_valid_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      data_port_q <= DS;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      data_port_q <= data_port_d;
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;

endmodule
